// File: rtl/sme_pkg.sv
// Shared definitions for the SME host driver: character constants,
// buffer depth defaults and the controller state encoding.
package sme_pkg;

  localparam logic [7:0] HEAD  = 8'h5E;
  localparam logic [7:0] STAR  = 8'h2A;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] END   = 8'h24;
  localparam logic [7:0] SPACE = 8'h20;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEND   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

endpackage

// File: rtl/sme_char_buf.sv
// Byte buffer with a saturating length counter. Bytes beyond DEPTH are
// dropped; wr_first restarts the frame at index 0.
module sme_char_buf #(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_first,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] len
);

  localparam logic [LW-1:0] LEN_ONE = {{(LW-1){1'b0}}, 1'b1};

  logic [7:0]    mem_r [DEPTH];
  logic [LW-1:0] len_r;
  logic [AW-1:0] wr_addr_s;
  logic          wr_do_s;

  // write address and overflow gating
  always_comb begin
    wr_addr_s = wr_first ? {AW{1'b0}} : len_r[AW-1:0];
    wr_do_s   = wr_en & (wr_first | (len_r < LW'(DEPTH)));
  end

  // frame length, saturating at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      len_r <= {LW{1'b0}};
    end else if (wr_do_s) begin
      len_r <= wr_first ? LEN_ONE : len_r + LEN_ONE;
    end
  end

  // storage
  always_ff @(posedge clk) begin
    if (wr_do_s) begin
      mem_r[wr_addr_s] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_idx];
  assign len     = len_r;

endmodule

// File: rtl/sme_host.sv
// Host-side SME driver: buffers string/pattern frames, replays them onto the
// SME bus with gapless string->pattern sequencing, and returns the result.
module sme_host
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       busy
);

  localparam int SAW = $clog2(STR_MAX);
  localparam int SLW = SAW + 1;
  localparam int PAW = $clog2(PAT_MAX);
  localparam int PLW = PAW + 1;

  state_t         state_r, state_s;
  logic           kind_r, str_pending_r;
  logic [SAW-1:0] idx_r, idx_s;
  logic [7:0]     wcnt_r;
  logic [7:0]     chardata_r, char_s;
  logic           isstring_r, is_s, ispattern_r, ip_s;
  logic           res_valid_r, res_match_r, res_timeout_r;
  logic [4:0]     res_index_r;

  logic           accept_s, first_s, frame_kind_s, frame_end_s, start_send_s;
  logic           pat_done_s, timeout_s, str_wr_s, pat_wr_s;
  logic [SLW-1:0] slen_s, idx_inc_s;
  logic [PLW-1:0] plen_s;
  logic [SAW-1:0] str_rd_s;
  logic [PAW-1:0] pat_rd_s;
  logic [7:0]     str_byte_s, pat_byte_s;

  assign in_ready = (state_r == ST_IDLE) | (state_r == ST_LOAD);
  assign busy     = (state_r != ST_IDLE);

  // frame acceptance and sequencing conditions
  always_comb begin
    first_s      = (state_r == ST_IDLE);
    accept_s     = in_valid & in_ready;
    frame_kind_s = first_s ? in_kind : kind_r;
    frame_end_s  = accept_s & in_last;
    start_send_s = frame_end_s & frame_kind_s;
    str_wr_s     = accept_s & ~frame_kind_s;
    pat_wr_s     = accept_s & frame_kind_s;
    idx_inc_s    = {1'b0, idx_r} + {{SAW{1'b0}}, 1'b1};
    pat_done_s   = ispattern_r & (idx_inc_s >= SLW'(plen_s));
    timeout_s    = ((wcnt_r + 8'd1) == 8'(TIMEOUT));
  end

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (str_wr_s),
    .wr_first (first_s),
    .wr_data  (in_data),
    .rd_idx   (str_rd_s),
    .rd_data  (str_byte_s),
    .len      (slen_s)
  );

  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (pat_wr_s),
    .wr_first (first_s),
    .wr_data  (in_data),
    .rd_idx   (pat_rd_s),
    .rd_data  (pat_byte_s),
    .len      (plen_s)
  );

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_LOAD: begin
        if (frame_end_s) begin
          state_s = frame_kind_s ? ST_SEND : ST_IDLE;
        end else if (accept_s) begin
          state_s = ST_LOAD;
        end else begin
          state_s = state_r;
        end
      end
      ST_SEND:   state_s = pat_done_s ? ST_WAIT : ST_SEND;
      ST_WAIT:   state_s = (valid | timeout_s) ? ST_REPORT : ST_WAIT;
      ST_REPORT: state_s = res_ready ? ST_IDLE : ST_REPORT;
      default:   state_s = ST_IDLE;
    endcase
  end

  // next bus beat; a single-byte pattern frame forwards in_data as pat[0]
  always_comb begin
    char_s   = 8'h00;
    is_s     = 1'b0;
    ip_s     = 1'b0;
    idx_s    = idx_r;
    str_rd_s = {SAW{1'b0}};
    pat_rd_s = {PAW{1'b0}};
    if (start_send_s) begin
      idx_s = {SAW{1'b0}};
      if (str_pending_r) begin
        is_s   = 1'b1;
        char_s = str_byte_s;
      end else begin
        ip_s   = 1'b1;
        char_s = first_s ? in_data : pat_byte_s;
      end
    end else if ((state_r == ST_SEND) && isstring_r) begin
      if (idx_inc_s < slen_s) begin
        str_rd_s = idx_inc_s[SAW-1:0];
        is_s     = 1'b1;
        char_s   = str_byte_s;
        idx_s    = idx_inc_s[SAW-1:0];
      end else begin
        ip_s     = 1'b1;
        char_s   = pat_byte_s;
        idx_s    = {SAW{1'b0}};
      end
    end else if ((state_r == ST_SEND) && !pat_done_s) begin
      pat_rd_s = idx_inc_s[PAW-1:0];
      ip_s     = 1'b1;
      char_s   = pat_byte_s;
      idx_s    = idx_inc_s[SAW-1:0];
    end else begin
      idx_s    = idx_r;
    end
  end

  // controller state, frame kind, pending string and wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      kind_r        <= 1'b0;
      str_pending_r <= 1'b0;
      idx_r         <= {SAW{1'b0}};
      wcnt_r        <= 8'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      wcnt_r  <= (state_r == ST_WAIT) ? wcnt_r + 8'd1 : 8'd0;
      if (accept_s && first_s) kind_r <= in_kind;
      if (start_send_s) begin
        str_pending_r <= 1'b0;
      end else if (frame_end_s && !frame_kind_s) begin
        str_pending_r <= 1'b1;
      end
    end
  end

  // registered SME bus
  always_ff @(posedge clk) begin
    if (reset) begin
      chardata_r  <= 8'h00;
      isstring_r  <= 1'b0;
      ispattern_r <= 1'b0;
    end else begin
      chardata_r  <= char_s;
      isstring_r  <= is_s;
      ispattern_r <= ip_s;
    end
  end

  // result capture; held until upstream takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_r   <= 1'b0;
      res_match_r   <= 1'b0;
      res_index_r   <= 5'd0;
      res_timeout_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && valid) begin
      res_valid_r   <= 1'b1;
      res_match_r   <= match;
      res_index_r   <= match_index;
      res_timeout_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && timeout_s) begin
      res_valid_r   <= 1'b1;
      res_match_r   <= 1'b0;
      res_index_r   <= 5'd0;
      res_timeout_r <= 1'b1;
    end else if ((state_r == ST_REPORT) && res_ready) begin
      res_valid_r   <= 1'b0;
      res_match_r   <= 1'b0;
      res_index_r   <= 5'd0;
      res_timeout_r <= 1'b0;
    end
  end

  assign chardata    = chardata_r;
  assign isstring    = isstring_r;
  assign ispattern   = ispattern_r;
  assign res_valid   = res_valid_r;
  assign res_match   = res_match_r;
  assign res_index   = res_index_r;
  assign res_timeout = res_timeout_r;

endmodule

// File: tb/tb_sme_host.sv
// Directed + randomized bench for sme_host; the bench plays upstream and SME
// and predicts the bus trace and result from a frame-level model.
module tb_sme_host;
  import sme_pkg::*;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, in_kind, in_last;
  logic [7:0] in_data, chardata;
  logic       isstring, ispattern, valid, match, res_valid, res_ready, res_match, res_timeout, busy;
  logic [4:0] match_index, res_index;

  sme_host dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kind(in_kind), .in_last(in_last), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match), .match_index(match_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .res_index(res_index), .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bus monitor: every driven beat with its cycle number, plus bus-rule violations
  logic [9:0] bus_q[$];
  int         bus_cyc[$];
  int         viol = 0;
  always @(negedge clk) begin
    if (isstring || ispattern) begin
      bus_q.push_back({isstring, ispattern, chardata});
      bus_cyc.push_back(cyc);
    end
    if ((isstring && ispattern) || (!isstring && !ispattern && chardata != 8'h00))
      viol <= viol + 1;
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [7:0] frame_q[$];
  logic [7:0] model_str[$];
  bit         model_pending = 1'b0;
  logic [9:0] exp_q[$];
  int         acc_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rbyte();
    case ($urandom_range(0, 7))
      0: return HEAD;
      1: return STAR;
      2: return DOT;
      3: return END;
      4: return SPACE;
      default: return 8'h61 + 8'($urandom_range(0, 25));
    endcase
  endfunction

  task automatic load_str(input string s);
    frame_q.delete();
    for (int i = 0; i < s.len(); i++) frame_q.push_back(s[i]);
  endtask

  task automatic rand_frame(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(rbyte());
  endtask

  // send frame_q upstream; the model keeps the latest string and predicts the bus trace
  task automatic send_frame(input bit kind);
    int w;
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_q[i];
      in_kind  = (i == 0) ? kind : 1'($urandom);
      in_last  = (i == frame_q.size() - 1);
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) chk("in_ready_stall", 32'(in_ready), 32'd1);
      acc_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!kind) begin
      model_str.delete();
      for (int i = 0; i < frame_q.size() && i < 32; i++) model_str.push_back(frame_q[i]);
      model_pending = 1'b1;
    end else begin
      exp_q.delete();
      if (model_pending) foreach (model_str[i]) exp_q.push_back({2'b10, model_str[i]});
      for (int i = 0; i < frame_q.size() && i < 8; i++) exp_q.push_back({2'b01, frame_q[i]});
      model_pending = 1'b0;
    end
  endtask

  // full pattern transaction: bus trace, SME response (or none), result handshake
  task automatic do_pattern(input bit use_valid, input int delay, input bit m,
                            input logic [4:0] mi, input int rdly);
    int w, ent;
    bit ok;
    logic sm, st;
    logic [4:0] si;
    bus_q.delete();
    bus_cyc.delete();
    send_frame(1'b1);
    w = 0;
    do begin @(negedge clk); w++; end
    while (!(bus_q.size() > 0 && !isstring && !ispattern) && w < 100);
    chk("send_done", 32'(w < 100), 32'd1);
    ent = cyc;
    chk("bus_len", 32'(bus_q.size()), 32'(exp_q.size()));
    ok = 1'b1;
    for (int i = 0; i < bus_q.size() && i < exp_q.size(); i++)
      if (bus_q[i] !== exp_q[i]) ok = 1'b0;
    chk("bus_data", 32'(ok), 32'd1);
    if (bus_q.size() > 0) begin
      chk("bus_gapless", 32'(bus_cyc[$] - bus_cyc[0] + 1), 32'(bus_q.size()));
      chk("bus_first_cycle", 32'(bus_cyc[0]), 32'(acc_cyc + 1));
    end
    chk("wait_busy", {30'd0, busy, in_ready}, 32'd2);
    if (rdly == 0) res_ready = 1'b1;
    if (use_valid) begin
      repeat (delay) begin
        @(negedge clk);
        match = 1'($urandom);
        match_index = 5'($urandom);
      end
      chk("res_before_valid", 32'(res_valid), 32'd0);
      valid = 1'b1; match = m; match_index = mi;
      @(negedge clk);
      valid = 1'b0; match = ~m; match_index = ~mi;
      chk("res_valid_latency", 32'(res_valid), 32'd1);
      chk("res_match", 32'(res_match), 32'(m));
      chk("res_index", 32'(res_index), 32'(mi));
      chk("res_timeout_clr", 32'(res_timeout), 32'd0);
    end else begin
      w = 0;
      while (!res_valid && w < 300) begin @(negedge clk); w++; end
      chk("timeout_cycle", 32'(cyc - ent), 32'd255);
      chk("timeout_res", {27'd0, res_match, res_index, res_timeout}, 32'd1);
    end
    sm = res_match; si = res_index; st = res_timeout;
    if (rdly > 0) begin
      ok = 1'b1;
      repeat (rdly) begin
        @(negedge clk);
        if (!res_valid || res_match !== sm || res_index !== si || res_timeout !== st || in_ready)
          ok = 1'b0;
      end
      chk("res_hold", 32'(ok), 32'd1);
      res_ready = 1'b1;
    end
    @(negedge clk);
    res_ready = 1'b0;
    chk("report_exit", {29'd0, busy, res_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int n, ns;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_kind = 1'b0; in_last = 1'b0;
    valid = 1'b0; match = 1'b0; match_index = 5'd0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus", {22'd0, chardata, isstring, ispattern}, 32'd0);
    chk("rst_res", {24'd0, res_valid, res_match, res_index, res_timeout}, 32'd0);

    // stray SME valid while idle is ignored
    valid = 1'b1; match = 1'b1; match_index = 5'd9;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("stray_valid", {30'd0, res_valid, busy}, 32'd0);

    // string then pattern, SME reports a hit at index 4
    load_str("abc de"); send_frame(1'b0);
    chk("string_silent", {30'd0, busy, isstring}, 32'd0);
    load_str("de");  do_pattern(1'b1, 3, 1'b1, 5'd4, 1);
    // pattern only, reusing the loaded string
    load_str("^ab"); do_pattern(1'b1, 0, 1'($urandom), 5'($urandom), 0);
    // SME never answers
    load_str("xyz"); do_pattern(1'b0, 0, 1'b0, 5'd0, 2);
    // overflow: 40-byte string, 10-byte pattern
    rand_frame(40); send_frame(1'b0);
    rand_frame(10); do_pattern(1'b1, 7, 1'b0, 5'd17, 0);
    // result held for 20 cycles
    load_str("a*"); do_pattern(1'b1, 2, 1'b1, 5'd31, 20);

    // reset on the third isstring cycle
    rand_frame(8); send_frame(1'b0);
    load_str("xy"); send_frame(1'b1);
    n = 0; ns = 0;
    while (n < 3 && ns < 50) begin
      @(negedge clk); ns++;
      if (isstring) n++;
    end
    chk("rst_reach_3rd", 32'(n), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("midsend_rst_outs",
        {18'd0, chardata, isstring, ispattern, res_valid, res_match, res_index, res_timeout},
        32'd0);
    chk("midsend_rst_ready", {30'd0, busy, in_ready}, 32'd1);
    reset = 1'b0;
    model_str.delete();
    model_pending = 1'b0;
    load_str("q.$"); do_pattern(1'b1, 1, 1'b1, 5'd2, 0);

    // randomized transactions, including back-to-back string overwrites
    for (int t = 0; t < 10; t++) begin
      ns = $urandom_range(0, 2);
      for (int k = 0; k < ns; k++) begin
        rand_frame($urandom_range(1, 40));
        send_frame(1'b0);
      end
      rand_frame($urandom_range(1, 10));
      do_pattern($urandom_range(0, 4) != 0, $urandom_range(0, 20), 1'($urandom),
                 5'($urandom), $urandom_range(0, 4));
    end

    chk("bus_rules", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
